ivf_stream_writer: RTL

//   IVF container muxer: inverse of the IVF frame-extraction path. Takes per-frame

---
 rtl/ivf_pkg.sv | 17 +
 rtl/ivf_hdr_byte_sel.sv | 46 ++++
 rtl/ivf_stream_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ivf_pkg.sv
// Shared constants and FSM state type for the IVF stream writer.
package ivf_pkg;
    localparam int          IVF_FILE_HDR_BYTES  = 32;
    localparam int          IVF_FRAME_HDR_BYTES = 12;
    localparam logic [31:0] IVF_SIGNATURE       = 32'h46494B44;
    localparam logic [15:0] IVF_VERSION         = 16'h0000;
    localparam logic [15:0] IVF_HDR_LEN         = 16'h0020;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILE_HDR,
        ST_WAIT_FRM,
        ST_FRM_HDR,
        ST_PAYLOAD,
        ST_DONE
    } ivf_state_e;
endpackage

// File: rtl/ivf_hdr_byte_sel.sv
// Combinational header byte selector: maps a byte index onto the 32-byte file
// header (static fields) or the 12-byte frame header (latched size and pts).
module ivf_hdr_byte_sel
    import ivf_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 64,
    parameter int unsigned FRAME_HEIGHT = 64,
    parameter logic [31:0] FOURCC       = 32'h32305641,
    parameter int unsigned RATE_NUM     = 30,
    parameter int unsigned RATE_DEN     = 1,
    parameter int unsigned NUM_FRAMES   = 2
) (
    input  logic        frame_hdr,
    input  logic [4:0]  idx,
    input  logic [31:0] size,
    input  logic [63:0] pts,
    output logic [7:0]  hdr_byte
);
    // Byte 0 sits in the least significant byte, so every field lands little-endian.
    localparam logic [255:0] FILE_VEC = {32'h0, 32'(NUM_FRAMES), 32'(RATE_DEN), 32'(RATE_NUM),
                                         16'(FRAME_HEIGHT), 16'(FRAME_WIDTH), FOURCC,
                                         IVF_HDR_LEN, IVF_VERSION, IVF_SIGNATURE};

    logic [127:0] frame_vec;
    logic [7:0]   file_bytes  [IVF_FILE_HDR_BYTES];
    logic [7:0]   frame_bytes [16];

    assign frame_vec = {32'h0, pts, size};

    genvar gi;
    generate
        for (gi = 0; gi < IVF_FILE_HDR_BYTES; gi++) begin : g_file
            assign file_bytes[gi] = FILE_VEC[gi*8 +: 8];
        end
        for (gi = 0; gi < 16; gi++) begin : g_frame
            assign frame_bytes[gi] = frame_vec[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        hdr_byte = file_bytes[idx];
        if (frame_hdr) begin
            hdr_byte = frame_bytes[idx[3:0]];
        end
    end
endmodule

// File: rtl/ivf_stream_writer.sv
// IVF muxer: file header, then per frame a 12-byte header and payload, through a
// registered byte output. Define IVF_AUTO_PTS_EN to replace frm_pts with the frame index.
module ivf_stream_writer
    import ivf_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 64,
    parameter int unsigned FRAME_HEIGHT = 64,
    parameter logic [31:0] FOURCC       = 32'h32305641,
    parameter int unsigned RATE_NUM     = 30,
    parameter int unsigned RATE_DEN     = 1,
    parameter int unsigned NUM_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frm_valid,
    output logic        frm_ready,
    input  logic [31:0] frm_size,
    input  logic [63:0] frm_pts,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_eof,
    output logic        busy,
    output logic        done,
    output logic        err_size
);
    localparam int FW = (NUM_FRAMES > 0) ? $clog2(NUM_FRAMES + 1) : 1;

    ivf_state_e     state_reg, state_next;
    logic [31:0]    byte_cnt_reg, byte_cnt_next;
    logic [FW-1:0]  frame_cnt_reg, frame_cnt_next;
    logic [31:0]    size_reg, size_next;
    logic [63:0]    pts_reg, pts_next;
    logic           err_reg, err_next;
    logic           out_valid_reg, out_valid_next;
    logic [7:0]     out_data_reg, out_data_next;
    logic           out_eof_reg, out_eof_next;

    logic           load_en;
    logic           hdr_frame;
    logic [4:0]     hdr_idx;
    logic [7:0]     hdr_byte;
    logic           last_frame;
    logic           last_payload;

    assign load_en      = !out_valid_reg || out_ready;
    assign hdr_frame    = (state_reg == ST_FRM_HDR);
    assign hdr_idx      = (state_reg == ST_FILE_HDR || hdr_frame) ? byte_cnt_reg[4:0] : 5'd0;
    assign last_frame   = (32'(frame_cnt_reg) + 32'd1 == NUM_FRAMES);
    assign last_payload = (byte_cnt_reg == size_reg - 32'd1);

    ivf_hdr_byte_sel #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .FRAME_HEIGHT(FRAME_HEIGHT),
        .FOURCC      (FOURCC),
        .RATE_NUM    (RATE_NUM),
        .RATE_DEN    (RATE_DEN),
        .NUM_FRAMES  (NUM_FRAMES)
    ) u_hdr_sel (
        .frame_hdr(hdr_frame),
        .idx      (hdr_idx),
        .size     (size_reg),
        .pts      (pts_reg),
        .hdr_byte (hdr_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            byte_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            size_reg      <= '0;
            pts_reg       <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_eof_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            size_reg      <= size_next;
            pts_reg       <= pts_next;
            err_reg       <= err_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_eof_reg   <= out_eof_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        size_next      = size_reg;
        pts_next       = pts_reg;
        err_next       = err_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_eof_next   = out_eof_reg;
        // A consumed (or empty) output slot drains unless something is loaded below.
        if (load_en) begin
            out_valid_next = 1'b0;
            out_eof_next   = 1'b0;
        end
        unique case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Byte 0 is issued on the start cycle itself when the slot is free.
                    state_next     = ST_FILE_HDR;
                    frame_cnt_next = '0;
                    byte_cnt_next  = 32'd0;
                    if (load_en) begin
                        out_valid_next = 1'b1;
                        out_data_next  = hdr_byte;
                        byte_cnt_next  = 32'd1;
                    end
                end
            end
            ST_FILE_HDR: begin
                if (load_en) begin
                    out_valid_next = 1'b1;
                    out_data_next  = hdr_byte;
                    byte_cnt_next  = byte_cnt_reg + 32'd1;
                    if (byte_cnt_reg == 32'(IVF_FILE_HDR_BYTES - 1)) begin
                        byte_cnt_next = 32'd0;
                        if (NUM_FRAMES == 0) begin
                            state_next   = ST_DONE;
                            out_eof_next = 1'b1;
                        end else begin
                            state_next = ST_WAIT_FRM;
                        end
                    end
                end
            end
            ST_WAIT_FRM: begin
                if (frm_valid) begin
                    state_next    = ST_FRM_HDR;
                    byte_cnt_next = 32'd0;
                    size_next     = frm_size;
`ifdef IVF_AUTO_PTS_EN
                    pts_next      = 64'(frame_cnt_reg);
`else
                    pts_next      = frm_pts;
`endif
                end
            end
            ST_FRM_HDR: begin
                if (load_en) begin
                    out_valid_next = 1'b1;
                    out_data_next  = hdr_byte;
                    byte_cnt_next  = byte_cnt_reg + 32'd1;
                    if (byte_cnt_reg == 32'(IVF_FRAME_HDR_BYTES - 1)) begin
                        byte_cnt_next = 32'd0;
                        if (size_reg != 32'd0) begin
                            state_next = ST_PAYLOAD;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + FW'(1);
                            state_next     = last_frame ? ST_DONE : ST_WAIT_FRM;
                            out_eof_next   = last_frame;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid && load_en) begin
                    out_valid_next = 1'b1;
                    out_data_next  = in_data;
                    byte_cnt_next  = byte_cnt_reg + 32'd1;
                    if (in_last != last_payload) begin
                        err_next = 1'b1;
                    end
                    if (last_payload) begin
                        byte_cnt_next  = 32'd0;
                        frame_cnt_next = frame_cnt_reg + FW'(1);
                        state_next     = last_frame ? ST_DONE : ST_WAIT_FRM;
                        out_eof_next   = last_frame;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef IVF_AUTO_PTS_EN
    logic unused_pts;
    assign unused_pts = ^frm_pts;
`endif

    assign frm_ready = (state_reg == ST_WAIT_FRM);
    assign in_ready  = (state_reg == ST_PAYLOAD) && load_en;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_eof   = out_eof_reg;
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign err_size  = err_reg;
endmodule
